// File: rtl/aes_lite_pkg.sv
// aes_lite_pkg
// Shared types and primitives for the AES-lite iterative cipher.
//   state_e      : engine FSM encoding (IDLE, KEYEXP, ROUND, DONE)
//   sbox4/isbox4 : 4-bit substitution and its inverse
//   sub_nib      : forward S-box on every nibble of a 64-bit vector
//   inv_sub_nib  : inverse S-box on every nibble of a 64-bit vector
//   rotl8/rotr8  : byte rotation confined to the low nbytes bytes
//   rc           : round constant, the round index in the low byte
//   key_fwd      : rk_r     = ROTL(rk_{r-1}) ^ RC(r)
//   key_inv      : rk_{r-1} = ROTR(rk_r ^ RC(r))
// Every vector helper works on a 64-bit container. Callers zero-extend
// their W-bit values and keep only the low W bits of the result. Bits
// above the active width are don't-care.
package aes_lite_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        ROUND  = 3'd2,
        DONE   = 3'd3
    } state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;
            4'h1: return 4'h5;
            4'h2: return 4'h6;
            4'h3: return 4'hB;
            4'h4: return 4'h9;
            4'h5: return 4'h0;
            4'h6: return 4'hA;
            4'h7: return 4'hD;
            4'h8: return 4'h3;
            4'h9: return 4'hE;
            4'hA: return 4'hF;
            4'hB: return 4'h8;
            4'hC: return 4'h4;
            4'hD: return 4'h7;
            4'hE: return 4'h1;
            default: return 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] isbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'h5;
            4'h1: return 4'hE;
            4'h2: return 4'hF;
            4'h3: return 4'h8;
            4'h4: return 4'hC;
            4'h5: return 4'h1;
            4'h6: return 4'h2;
            4'h7: return 4'hD;
            4'h8: return 4'hB;
            4'h9: return 4'h4;
            4'hA: return 4'h6;
            4'hB: return 4'h3;
            4'hC: return 4'h0;
            4'hD: return 4'h7;
            4'hE: return 4'h9;
            default: return 4'hA;
        endcase
    endfunction

    function automatic logic [63:0] sub_nib(input logic [63:0] v);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = sbox4(v[4*i +: 4]);
        end
        return r;
    endfunction

    function automatic logic [63:0] inv_sub_nib(input logic [63:0] v);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = isbox4(v[4*i +: 4]);
        end
        return r;
    endfunction

    // Rotate left by one byte inside the low nbytes bytes. The top active
    // byte wraps into byte 0. The loops use only constant indices, so no
    // select ever falls outside the 64-bit container.
    function automatic logic [63:0] rotl8(input logic [63:0] v, input int nbytes);
        logic [63:0] r;
        r = '0;
        for (int i = 1; i < 8; i++) begin
            if (i < nbytes) begin
                r[8*i +: 8] = v[8*(i-1) +: 8];
            end
        end
        for (int j = 0; j < 8; j++) begin
            if (j == nbytes - 1) begin
                r[7:0] = v[8*j +: 8];
            end
        end
        return r;
    endfunction

    // Rotate right by one byte inside the low nbytes bytes. Byte 0 wraps
    // into the top active byte.
    function automatic logic [63:0] rotr8(input logic [63:0] v, input int nbytes);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) begin
            if (i < nbytes - 1) begin
                r[8*i +: 8] = v[8*(i+1) +: 8];
            end
        end
        for (int j = 0; j < 8; j++) begin
            if (j == nbytes - 1) begin
                r[8*j +: 8] = v[7:0];
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] rc(input logic [3:0] r);
        return {60'd0, r};
    endfunction

    function automatic logic [63:0] key_fwd(input logic [63:0] rk, input logic [3:0] r,
                                            input int nbytes);
        return rotl8(rk, nbytes) ^ rc(r);
    endfunction

    function automatic logic [63:0] key_inv(input logic [63:0] rk, input logic [3:0] r,
                                            input int nbytes);
        return rotr8(rk ^ rc(r), nbytes);
    endfunction

endpackage

// File: rtl/aes_lite_round.sv
// aes_lite_round
// Combinational datapath for one cipher round, in either direction.
//   s, rk        : current state and round key (W = 8*NBYTES bits)
//   decrypt      : 0 = forward round, 1 = inverse round
//   first_round  : round index is 1. In the inverse direction this is the
//                  final step, where rk0 is folded in.
//   round        : round index r, which feeds the round constant
//   s_next       : state after this round
//   rk_next      : rk_r for the forward direction, rk_{r-1} for the inverse
module aes_lite_round
    import aes_lite_pkg::*;
#(
    parameter int NBYTES = 2,
    localparam int W = 8 * NBYTES
) (
    input  logic [W-1:0] s,
    input  logic [W-1:0] rk,
    input  logic         decrypt,
    input  logic         first_round,
    input  logic [3:0]   round,
    output logic [W-1:0] s_next,
    output logic [W-1:0] rk_next
);

    always_comb begin
        s_next  = '0;
        rk_next = '0;
        if (decrypt) begin
            // The incoming rk is rk_r. Undo the key mix, the rotation and the
            // S-box, then step the key back to rk_{r-1}.
            rk_next = W'(key_inv(64'(rk), round, NBYTES));
            s_next  = W'(inv_sub_nib(rotr8(64'(s ^ rk), NBYTES)));
            if (first_round) begin
                // rk_next is rk0 here. Mixing it in now avoids a separate
                // whitening cycle.
                s_next = s_next ^ rk_next;
            end
        end else begin
            // Step the key forward to rk_r first. That new key is mixed into
            // this round's state.
            rk_next = W'(key_fwd(64'(rk), round, NBYTES));
            s_next  = W'(rotl8(sub_nib(64'(s)), NBYTES)) ^ rk_next;
        end
    end

endmodule

// File: rtl/aes_lite_engine.sv
// aes_lite_engine
// Iterative SPN cipher engine. It runs one round per clock, in encrypt or
// decrypt mode per transaction, with valid/ready handshakes on both sides.
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   in_valid     : block/key/mode offered; accepted when in_ready is high
//   in_ready     : high only in IDLE
//   in_decrypt   : 0 = encrypt, 1 = decrypt; sampled at accept
//   in_data      : plaintext or ciphertext (W bits)
//   in_key       : round-0 key rk0 (W bits)
//   abort        : synchronous cancel back to IDLE; beats every transition
//   out_valid    : result valid; held until out_ready
//   out_ready    : consumer accepts the result
//   out_data     : result; keeps its last value after the handshake or abort
//   busy         : state is not IDLE
//   round_count  : current round index; 0 in IDLE and DONE
//   state        : FSM encoding (debug)
module aes_lite_engine
    import aes_lite_pkg::*;
#(
    parameter int NBYTES  = 2,
    parameter int NROUNDS = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic [W-1:0] in_data,
    input  logic [W-1:0] in_key,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic [3:0]   round_count,
    output logic [2:0]   state
);

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

    state_e       st;
    logic [W-1:0] s;
    logic [W-1:0] rk;
    logic         decrypt;
    logic [W-1:0] s_nxt;
    logic [W-1:0] rk_nxt;
    logic         first_round;
    logic         last_round;

    assign state       = st;
    assign first_round = (round_count == 4'd1);
    // Encrypt counts up and ends at NROUNDS. Decrypt counts down and ends
    // at round 1.
    assign last_round  = decrypt ? first_round : (round_count == LAST_ROUND);

    aes_lite_round #(
        .NBYTES (NBYTES)
    ) u_round (
        .s           (s),
        .rk          (rk),
        .decrypt     (decrypt),
        .first_round (first_round),
        .round       (round_count),
        .s_next      (s_nxt),
        .rk_next     (rk_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            round_count <= 4'd0;
            s           <= '0;
            rk          <= '0;
            decrypt     <= 1'b0;
        end else if (abort) begin
            // Drop the block. out_data keeps the previous result.
            st          <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            round_count <= 4'd0;
        end else begin
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        decrypt     <= in_decrypt;
                        rk          <= in_key;
                        round_count <= 4'd1;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        if (in_decrypt) begin
                            // The inverse rounds need rk_N first, so the key
                            // schedule runs forward before any data round.
                            s  <= in_data;
                            st <= KEYEXP;
                        end else begin
                            // Initial whitening with rk0 happens at accept.
                            s  <= in_data ^ in_key;
                            st <= ROUND;
                        end
                    end
                end

                KEYEXP: begin
                    rk <= W'(key_fwd(64'(rk), round_count, NBYTES));
                    if (round_count == LAST_ROUND) begin
                        // round_count already equals N, which is the first
                        // inverse round.
                        st <= ROUND;
                    end else begin
                        round_count <= round_count + 4'd1;
                    end
                end

                ROUND: begin
                    s  <= s_nxt;
                    rk <= rk_nxt;
                    if (last_round) begin
                        st          <= DONE;
                        round_count <= 4'd0;
                        out_valid   <= 1'b1;
                        out_data    <= s_nxt;
                    end else if (decrypt) begin
                        round_count <= round_count - 4'd1;
                    end else begin
                        round_count <= round_count + 4'd1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        st        <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    st          <= IDLE;
                    in_ready    <= 1'b1;
                    out_valid   <= 1'b0;
                    busy        <= 1'b0;
                    round_count <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_lite_engine.sv
// tb_aes_lite_engine
// Scoreboard bench for two engine configurations:
//   u_dut0 : NBYTES=1, NROUNDS=1
//   u_dut1 : NBYTES=2, NROUNDS=2
// Stimulus pushes the expected result, latency and accept cycle into a
// per-DUT queue. A monitor pops an entry on every new out_valid.
module tb_aes_lite_engine;

    localparam int NR0 = 1;
    localparam int NR1 = 2;

    typedef struct {
        logic [15:0] exp;
        int          lat;
        int          acc;
        int          mode;   // 0 = capture result, 1 = compare data
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic        iv0, idec0, ab0, or0;
    logic [7:0]  id0, ik0;
    logic        ir0, ov0, bz0;
    logic [7:0]  od0;
    logic [3:0]  rc0;
    logic [2:0]  st0;

    logic        iv1, idec1, ab1, or1;
    logic [15:0] id1, ik1;
    logic        ir1, ov1, bz1;
    logic [15:0] od1;
    logic [3:0]  rc1;
    logic [2:0]  st1;

    exp_t        q0[$];
    exp_t        q1[$];
    logic        seen[2];
    logic [15:0] held[2];
    logic [15:0] ct[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_lite_engine #(.NBYTES(1), .NROUNDS(NR0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_decrypt(idec0),
        .in_data(id0), .in_key(ik0), .abort(ab0), .out_valid(ov0), .out_ready(or0),
        .out_data(od0), .busy(bz0), .round_count(rc0), .state(st0)
    );

    aes_lite_engine #(.NBYTES(2), .NROUNDS(NR1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_decrypt(idec1),
        .in_data(id1), .in_key(ik1), .abort(ab1), .out_valid(ov1), .out_ready(or1),
        .out_data(od1), .busy(bz1), .round_count(rc1), .state(st1)
    );

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ir0 : ir1;
    endfunction
    function automatic logic ovld(input int sel);
        return (sel == 0) ? ov0 : ov1;
    endfunction
    function automatic logic obusy(input int sel);
        return (sel == 0) ? bz0 : bz1;
    endfunction
    function automatic logic [15:0] odata(input int sel);
        return (sel == 0) ? {8'h00, od0} : od1;
    endfunction
    function automatic logic [3:0] orc(input int sel);
        return (sel == 0) ? rc0 : rc1;
    endfunction
    function automatic logic [2:0] ost(input int sel);
        return (sel == 0) ? st0 : st1;
    endfunction
    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=timeout expected=event (t=%0t)", name, $time);
    endtask

    task automatic drive(input int sel, input logic v, input logic dec,
                         input logic [15:0] d, input logic [15:0] k);
        if (sel == 0) begin
            iv0 = v; idec0 = dec; id0 = d[7:0]; ik0 = k[7:0];
        end else begin
            iv1 = v; idec1 = dec; id1 = d; ik1 = k;
        end
    endtask

    // Offers one block and returns #1 after the accept edge.
    // mode 2 means the block is expected never to complete.
    task automatic issue(input int sel, input logic dec, input logic [15:0] d,
                         input logic [15:0] k, input int mode, input logic [15:0] exp);
        int   g;
        exp_t e;
        g = 0;
        while (!rdy(sel) && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) fail_now($sformatf("issue_timeout%0d", sel));
        drive(sel, 1'b1, dec, d, k);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
        if (mode != 2) begin
            e.exp  = exp;
            e.lat  = (dec ? 2 : 1) * ((sel == 0) ? NR0 : NR1);
            e.acc  = cyc;
            e.mode = mode;
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
    endtask

    task automatic wait_idle(input int sel);
        int g;
        g = 0;
        while ((qsize(sel) != 0 || !rdy(sel)) && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) fail_now($sformatf("idle_timeout%0d", sel));
    endtask

    task automatic wait_out(input int sel);
        int g;
        g = 0;
        while (!ovld(sel) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) fail_now($sformatf("out_timeout%0d", sel));
    endtask

    task automatic chk_idle(input int sel, input string tag);
        chk($sformatf("%s_in_ready%0d", tag, sel), 32'(rdy(sel)), 32'd1);
        chk($sformatf("%s_out_valid%0d", tag, sel), 32'(ovld(sel)), 32'd0);
        chk($sformatf("%s_busy%0d", tag, sel), 32'(obusy(sel)), 32'd0);
        chk($sformatf("%s_round%0d", tag, sel), 32'(orc(sel)), 32'd0);
        chk($sformatf("%s_state%0d", tag, sel), 32'(ost(sel)), 32'd0);
    endtask

    task automatic mon(input int sel);
        exp_t        e;
        logic [15:0] d;
        d = odata(sel);
        if (!ovld(sel)) begin
            seen[sel] = 1'b0;
            return;
        end
        if (seen[sel]) begin
            chk($sformatf("hold_data%0d", sel), 32'(d), 32'(held[sel]));
            return;
        end
        seen[sel] = 1'b1;
        held[sel] = d;
        if (qsize(sel) == 0) begin
            chk($sformatf("unexpected_out%0d", sel), 32'(ovld(sel)), 32'd0);
            return;
        end
        if (sel == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        chk($sformatf("latency%0d", sel), 32'(cyc - e.acc), 32'(e.lat));
        if (e.mode == 1) chk($sformatf("data%0d", sel), 32'(d), 32'(e.exp));
        else             ct[sel] = d;
    endtask

    // Monitor: samples on the falling edge, clear of the active edge.
    initial begin
        seen[0] = 1'b0; seen[1] = 1'b0;
        held[0] = '0;   held[1] = '0;
        ct[0]   = '0;   ct[1]   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon(0);
                mon(1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pt, key;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        ab0 = 1'b0; ab1 = 1'b0;
        or0 = 1'b1; or1 = 1'b1;
        #2;
        chk_idle(0, "reset");
        chk_idle(1, "reset");
        chk("reset_data0", 32'(od0), 32'd0);
        chk("reset_data1", 32'(od1), 32'd0);
        #10;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single-round, single-byte vectors
        issue(0, 1'b0, 16'h0000, 16'h0000, 1, 16'h00CD);
        issue(0, 1'b1, 16'h00CD, 16'h0000, 1, 16'h0000);
        issue(0, 1'b0, 16'h005A, 16'h003C, 1, 16'h0097);
        issue(0, 1'b1, 16'h0097, 16'h003C, 1, 16'h005A);
        wait_idle(0);

        // Two-round, two-byte vectors
        issue(1, 1'b0, 16'h0000, 16'h0000, 1, 16'h4646);
        issue(1, 1'b1, 16'h4646, 16'h0000, 1, 16'h0000);
        issue(1, 1'b0, 16'h1234, 16'h0000, 1, 16'h0C8C);
        issue(1, 1'b1, 16'h0C8C, 16'h0000, 1, 16'h1234);
        wait_idle(1);

        // Backpressure. A new offer during DONE must be ignored.
        or1 = 1'b0;
        issue(1, 1'b0, 16'h1234, 16'h0000, 1, 16'h0C8C);
        wait_out(1);
        drive(1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(ov1), 32'd1);
            chk("bp_in_ready", 32'(ir1), 32'd0);
            chk("bp_state", 32'(st1), 32'd3);
            chk("bp_round", 32'(rc1), 32'd0);
            chk("bp_data", 32'(od1), 32'h0C8C);
        end
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        or1 = 1'b1;
        @(posedge clk); #1;
        chk_idle(1, "bp_release");
        @(posedge clk); #1;
        chk("bp_no_accept", 32'(bz1), 32'd0);

        // Abort mid-ROUND on a decrypt
        issue(1, 1'b1, 16'h4646, 16'h0000, 2, 16'h0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_pre_state", 32'(st1), 32'd2);
        ab1 = 1'b1;
        @(posedge clk); #1;
        ab1 = 1'b0;
        chk_idle(1, "abort_round");
        chk("abort_keeps_data", 32'(od1), 32'h0C8C);
        issue(1, 1'b0, 16'h0000, 16'h0000, 1, 16'h4646);
        wait_idle(1);

        // Abort in DONE, coinciding with out_ready
        or1 = 1'b0;
        issue(1, 1'b0, 16'h1234, 16'h0000, 1, 16'h0C8C);
        wait_out(1);
        or1 = 1'b1;
        ab1 = 1'b1;
        @(posedge clk); #1;
        ab1 = 1'b0;
        chk_idle(1, "abort_done");
        chk("abort_done_data", 32'(od1), 32'h0C8C);
        issue(1, 1'b1, 16'h0C8C, 16'h0000, 1, 16'h1234);
        wait_idle(1);

        // Asynchronous reset during KEYEXP
        issue(1, 1'b1, 16'h4646, 16'h0000, 2, 16'h0000);
        chk("rst_pre_state", 32'(st1), 32'd1);
        rst = 1'b1;
        #1;
        chk_idle(1, "async_rst");
        chk("async_rst_data1", 32'(od1), 32'd0);
        chk("async_rst_data0", 32'(od0), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(1, 1'b0, 16'h0000, 16'h0000, 1, 16'h4646);
        wait_idle(1);

        // Encrypt then decrypt gives back the original block
        for (int i = 0; i < 20; i++) begin
            for (int sel = 0; sel < 2; sel++) begin
                pt  = 16'($urandom);
                key = 16'($urandom);
                if (sel == 0) begin
                    pt  = pt & 16'h00FF;
                    key = key & 16'h00FF;
                end
                issue(sel, 1'b0, pt, key, 0, 16'h0000);
                wait_idle(sel);
                issue(sel, 1'b1, ct[sel], key, 1, pt);
                wait_idle(sel);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("final_q0_empty", 32'(q0.size()), 32'd0);
        chk("final_q1_empty", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
